// File: rtl/uart_tx_core_if.sv
// rtl/uart_tx_core_if.sv - register-side and serial-side signals of the UART transmit engine
interface uart_tx_core_if #(
   parameter int DBIT   = 8,
   parameter int BAUD_W = 8
);
   logic [BAUD_W-1:0] baud_val;
   logic [DBIT-1:0]   data_in;
   logic              parity_en;
   logic              parity_odd;
   logic              tx_load;
   logic              tx;
   logic              tf_TXRDY;
   logic              tx_busy;
   logic              tx_ovr;

   modport master (
      output baud_val, data_in, parity_en, parity_odd, tx_load,
      input  tx, tf_TXRDY, tx_busy, tx_ovr
   );

   modport slave (
      input  baud_val, data_in, parity_en, parity_odd, tx_load,
      output tx, tf_TXRDY, tx_busy, tx_ovr
   );
endinterface

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART frame serializer with one-entry holding register
module uart_tx_core #(
   parameter int DBIT   = 8,
   parameter int BAUD_W = 8
) (
   input  logic          pclk,
   input  logic          preset,
   uart_tx_core_if.slave bus
);
   localparam int BCW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DBIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state_q, state_d;
   logic              hold_valid_q, hold_valid_d;
   logic [DBIT-1:0]   hold_data_q, hold_data_d;
   logic              hold_pen_q, hold_pen_d;
   logic              hold_podd_q, hold_podd_d;
   logic [BAUD_W-1:0] hold_baud_q, hold_baud_d;
   logic [DBIT-1:0]   shift_q, shift_d;
   logic              pen_q, pen_d;
   logic              par_q, par_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BAUD_W-1:0] cnt_q, cnt_d;
   logic [BCW-1:0]    bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              rdy_q, busy_q, ovr_q;
   logic              accept, tick, load_frame;

   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_pen_d   = hold_pen_q;
      hold_podd_d  = hold_podd_q;
      hold_baud_d  = hold_baud_q;
      shift_d      = shift_q;
      pen_d        = pen_q;
      par_d        = par_q;
      baud_d       = baud_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      load_frame   = 1'b0;
      accept       = bus.tx_load & rdy_q;
      tick         = (cnt_q == baud_q);

      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = bus.data_in;
         hold_pen_d   = bus.parity_en;
         hold_podd_d  = bus.parity_odd;
         hold_baud_d  = bus.baud_val;
      end

      case (state_q)
         IDLE:   if (hold_valid_q) load_frame = 1'b1;
         START:  if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                 end
         DATA:   if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                       state_d = pen_q ? PARITY : STOP;
                       bit_d   = '0;
                    end else begin
                       bit_d = bit_q + 1'b1;
                    end
                 end
         PARITY: if (tick) state_d = STOP;
         STOP:   if (tick) begin
                    if (hold_valid_q) load_frame = 1'b1;
                    else              state_d    = IDLE;
                 end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;

      // A held byte moves into the shifter from IDLE or straight out of STOP (no idle gap)
      if (load_frame) begin
         state_d      = START;
         hold_valid_d = 1'b0;
         shift_d      = hold_data_q;
         pen_d        = hold_pen_q;
         par_d        = (^hold_data_q) ^ hold_podd_q;
         baud_d       = hold_baud_q;
         cnt_d        = '0;
         bit_d        = '0;
      end

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q      <= IDLE;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_pen_q   <= 1'b0;
         hold_podd_q  <= 1'b0;
         hold_baud_q  <= '0;
         shift_q      <= '0;
         pen_q        <= 1'b0;
         par_q        <= 1'b0;
         baud_q       <= '0;
         cnt_q        <= '0;
         bit_q        <= '0;
         tx_q         <= 1'b1;
         rdy_q        <= 1'b1;
         busy_q       <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_pen_q   <= hold_pen_d;
         hold_podd_q  <= hold_podd_d;
         hold_baud_q  <= hold_baud_d;
         shift_q      <= shift_d;
         pen_q        <= pen_d;
         par_q        <= par_d;
         baud_q       <= baud_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         tx_q         <= tx_d;
         rdy_q        <= ~hold_valid_d;
         busy_q       <= (state_d != IDLE);
         ovr_q        <= bus.tx_load & ~rdy_q;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tf_TXRDY = rdy_q;
   assign bus.tx_busy  = busy_q;
   assign bus.tx_ovr   = ovr_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed scoreboard bench for uart_tx_core
module tb_uart_tx_core;
   logic pclk = 1'b0;
   logic preset;

   uart_tx_core_if #(.DBIT(8), .BAUD_W(8)) bus();

   uart_tx_core #(.DBIT(8), .BAUD_W(8)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   always #5 pclk = ~pclk;

   int   errors = 0;
   int   checks = 0;
   logic sb[$];
   int   busy_cycles = 0;
   int   busy_falls = 0;
   int   rdy_run = 0;
   int   last_rdy_run = 0;
   logic prev_busy = 1'b0;
   int   falls0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_level(input logic v, input int baud);
      for (int k = 0; k <= baud; k++) sb.push_back(v);
   endtask

   // Expected per-cycle tx levels of one frame, pushed when the byte is offered
   task automatic push_frame(input logic [7:0] d, input logic pen, input logic podd, input int baud);
      push_level(1'b0, baud);
      for (int b = 0; b < 8; b++) push_level(d[b], baud);
      if (pen) push_level((^d) ^ podd, baud);
      push_level(1'b1, baud);
   endtask

   task automatic load(input logic [7:0] d, input logic pen, input logic podd);
      bus.data_in    = d;
      bus.parity_en  = pen;
      bus.parity_odd = podd;
      bus.tx_load    = 1'b1;
      @(negedge pclk);
      bus.tx_load    = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int i;
      for (i = 0; i < bound && !(bus.tx_busy == 1'b0 && sb.size() == 0); i++) @(negedge pclk);
      chk("idle_timeout", 32'(i < bound), 32'd1);
   endtask

   always @(negedge pclk) begin
      if (preset) begin
         rdy_run   = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus.tx_busy) begin
            busy_cycles++;
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
            else                chk("tx_bit", 32'(bus.tx), 32'(sb.pop_front()));
         end else begin
            chk("tx_idle_high", 32'(bus.tx), 32'd1);
         end
         if (prev_busy && !bus.tx_busy) busy_falls++;
         prev_busy = bus.tx_busy;
         if (!bus.tf_TXRDY) rdy_run++;
         else if (rdy_run != 0) begin
            last_rdy_run = rdy_run;
            rdy_run      = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      preset         = 1'b1;
      bus.baud_val   = 8'd3;
      bus.data_in    = 8'h00;
      bus.parity_en  = 1'b0;
      bus.parity_odd = 1'b0;
      bus.tx_load    = 1'b0;
      repeat (2) @(negedge pclk);
      chk("rst_tx", 32'(bus.tx), 32'd1);
      chk("rst_rdy", 32'(bus.tf_TXRDY), 32'd1);
      chk("rst_busy", 32'(bus.tx_busy), 32'd0);
      chk("rst_ovr", 32'(bus.tx_ovr), 32'd0);
      preset = 1'b0;
      @(negedge pclk);

      // basic frame, 4-cycle bits
      bus.baud_val = 8'd3;
      busy_cycles  = 0;
      push_frame(8'hA5, 1'b0, 1'b0, 3);
      load(8'hA5, 1'b0, 1'b0);
      chk("e0_rdy_low", 32'(bus.tf_TXRDY), 32'd0);
      chk("e0_busy_low", 32'(bus.tx_busy), 32'd0);
      @(negedge pclk);
      chk("e1_rdy_high", 32'(bus.tf_TXRDY), 32'd1);
      chk("e1_busy_high", 32'(bus.tx_busy), 32'd1);
      chk("e1_start_bit", 32'(bus.tx), 32'd0);
      wait_idle(200);
      chk("basic_busy_len", 32'(busy_cycles), 32'd40);
      chk("basic_rdy_low_len", 32'(last_rdy_run), 32'd1);

      // parity even then odd
      bus.baud_val = 8'd1;
      busy_cycles  = 0;
      push_frame(8'h9A, 1'b1, 1'b0, 1);
      load(8'h9A, 1'b1, 1'b0);
      wait_idle(200);
      chk("par_even_len", 32'(busy_cycles), 32'd22);
      busy_cycles = 0;
      push_frame(8'h9A, 1'b1, 1'b1, 1);
      load(8'h9A, 1'b1, 1'b1);
      wait_idle(200);
      chk("par_odd_len", 32'(busy_cycles), 32'd22);

      // back-to-back at one-cycle bits
      bus.baud_val = 8'd0;
      busy_cycles  = 0;
      falls0       = busy_falls;
      push_frame(8'h01, 1'b0, 1'b0, 0);
      push_frame(8'hFF, 1'b0, 1'b0, 0);
      load(8'h01, 1'b0, 1'b0);
      repeat (2) @(negedge pclk);
      load(8'hFF, 1'b0, 1'b0);
      wait_idle(200);
      chk("b2b_busy_len", 32'(busy_cycles), 32'd20);
      chk("b2b_no_gap", 32'(busy_falls - falls0), 32'd1);
      chk("b2b_rdy_low_len", 32'(last_rdy_run), 32'd8);

      // overrun while the holding register is full
      bus.baud_val = 8'd3;
      falls0       = busy_falls;
      push_frame(8'h3C, 1'b0, 1'b0, 3);
      push_frame(8'hC3, 1'b0, 1'b0, 3);
      load(8'h3C, 1'b0, 1'b0);
      repeat (6) @(negedge pclk);
      load(8'hC3, 1'b0, 1'b0);
      @(negedge pclk);
      load(8'h55, 1'b0, 1'b0);
      chk("ovr_pulse", 32'(bus.tx_ovr), 32'd1);
      @(negedge pclk);
      chk("ovr_one_cycle", 32'(bus.tx_ovr), 32'd0);
      wait_idle(400);
      chk("ovr_single_burst", 32'(busy_falls - falls0), 32'd1);

      // divisor change mid-frame applies to the next frame only
      bus.baud_val = 8'd3;
      busy_cycles  = 0;
      push_frame(8'h5A, 1'b0, 1'b0, 3);
      load(8'h5A, 1'b0, 1'b0);
      repeat (8) @(negedge pclk);
      bus.baud_val = 8'd7;
      push_frame(8'h0F, 1'b0, 1'b0, 7);
      load(8'h0F, 1'b0, 1'b0);
      wait_idle(400);
      chk("baud_change_len", 32'(busy_cycles), 32'd120);

      // reset mid-frame with a byte held
      bus.baud_val = 8'd3;
      push_frame(8'h81, 1'b0, 1'b0, 3);
      load(8'h81, 1'b0, 1'b0);
      repeat (3) @(negedge pclk);
      load(8'h42, 1'b0, 1'b0);
      repeat (6) @(negedge pclk);
      preset = 1'b1;
      sb.delete();
      @(negedge pclk);
      chk("mid_rst_tx", 32'(bus.tx), 32'd1);
      chk("mid_rst_rdy", 32'(bus.tf_TXRDY), 32'd1);
      chk("mid_rst_busy", 32'(bus.tx_busy), 32'd0);
      chk("mid_rst_ovr", 32'(bus.tx_ovr), 32'd0);
      preset      = 1'b0;
      busy_cycles = 0;
      repeat (60) @(negedge pclk);
      chk("mid_rst_no_restart", 32'(busy_cycles), 32'd0);
      push_frame(8'h7E, 1'b0, 1'b0, 3);
      load(8'h7E, 1'b0, 1'b0);
      wait_idle(200);
      chk("post_rst_len", 32'(busy_cycles), 32'd40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial transmit engine of the UART, directly downstream of the APB register slave. It takes the baud divisor (`baud_val`), transmit byte (`data_in`) and parity enable from the slave's register outputs. It frames and shifts bytes out on `tx` through a one-entry holding register plus a shift register, and returns `tf_TXRDY` to the slave's TX-ready status input.

## Interface
- `DBIT`, 8, data bits per frame (matches the register width).
- `BAUD_W`, 8, width of the baud divisor.
- `pclk`  in  1  system clock; all logic on its rising edge.
- `preset`  in  1  synchronous, active-high reset.
- `baud_val`  in  BAUD_W  baud divisor; bit period = baud_val+1 pclk cycles.
- `data_in`  in  DBIT  byte to transmit; sampled only on an accepted `tx_load`.
- `parity_en`  in  1  1 = append a parity bit.
- `parity_odd`  in  1  1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `tx_load`  in  1  one-cycle write strobe: push `data_in` into the holding register.
- `tx`  out  1  serial line; idle high.
- `tf_TXRDY`  out  1  1 = holding register empty, `tx_load` will be accepted.
- `tx_busy`  out  1  1 = a frame is on the line (state ≠ IDLE).
- `tx_ovr`  out  1  one-cycle pulse: `tx_load` arrived while `tf_TXRDY`=0; byte dropped.

## Operation
- Holding register:
  - On a clock edge with `tx_load`=1 and `tf_TXRDY`=1, capture `data_in`, `parity_en`, `parity_odd` and `baud_val`. Set `hold_valid`; `tf_TXRDY`=0 after that edge.
  - `tf_TXRDY` is the registered value of `~hold_valid`. The accept decision uses the value present before the edge, even if the slot frees on that same edge.
  - `tx_load` with `tf_TXRDY`=0: data is not captured and `tx_ovr`=1 for exactly one cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If `hold_valid`, on the next edge transfer the holding contents to the shifter/config registers, clear `hold_valid`, go to START.
  - START: `tx`=0 for one bit period, then DATA.
  - DATA: `tx`=shifter[0], LSB first. Shift right each bit tick. After DBIT bits, go to PARITY if the latched `parity_en`, else STOP.
  - PARITY: `tx` = XOR of the latched byte, XOR the latched `parity_odd`.
  - STOP: `tx`=1 for one bit period. At the end of the bit, if `hold_valid` then transfer and go directly to START (no idle gap), else go to IDLE.
- Baud counter:
  - Counts 0..latched baud_val; bit tick when the count equals baud_val, then wrap to 0.
  - Reset to 0 on every transfer into START.
  - Uses the divisor latched at load; `baud_val` changes mid-frame take effect on the next frame.
  - `baud_val`=0 gives a one-cycle bit period.
- Bit counter: 0..DBIT-1, width ceil(log2(DBIT)).

## Timing
- Reset (any state, mid-frame included), values after the edge: `tx`=1, `tf_TXRDY`=1, `tx_busy`=0, `tx_ovr`=0, state IDLE, `hold_valid`=0, counters 0. Any in-flight frame and held byte are discarded.
- Load from idle:
  - Edge E0 accepts `tx_load`.
  - Edge E1: `tx` falls, `tx_busy`=1, `tf_TXRDY`=1.
  - Latency from the `tx_load` edge to the start bit is 1 cycle.
- Frame length = (1 + DBIT + parity_en + 1) × (baud_val+1) cycles.
- `tx_busy` falls on the edge ending STOP when no byte is held.
- `tx_busy` stays 1 across back-to-back frames.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic frame: reset, `baud_val`=3, `parity_en`=0, load 0xA5.
  - `tx` holds each level 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - Total 40 cycles; `tx_busy` high exactly 40 cycles.
  - `tf_TXRDY` low for only 1 cycle.
- Parity: `baud_val`=1, load 0x9A with `parity_en`=1.
  - With `parity_odd`=0: data bits 0,1,0,1,1,0,0,1, parity bit 0; frame 22 cycles.
  - Repeat with `parity_odd`=1: parity bit 1.
- Back-to-back: `baud_val`=0, load 0x01, then load 0xFF while the first frame is in DATA.
  - Second start bit immediately follows the first stop bit; no idle gap.
  - `tf_TXRDY` returns to 1 on the transfer edge.
- Overrun: during a frame with the holding register full, pulse `tx_load` with 0x55.
  - `tx_ovr`=1 for 1 cycle; 0x55 never appears on `tx`.
  - The held byte is sent unchanged.
- Mid-frame changes: `baud_val` changed 3→7 during the frame's DATA bits.
  - Current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- Reset mid-frame: assert `preset` in DATA with a byte held.
  - Next cycle: `tx`=1, `tf_TXRDY`=1, `tx_busy`=0.
  - No further start bit until a new `tx_load`.
